xc20xx_clbk_seq: RTL
====================

// Module: xc20xx_clbk_seq
// PURPOSE
//  Parametrised next-generation XC20XX CLB: two K-input LUTs (F, G) with per-input source muxes,
//  F/G select mux, a D flip-flop with Q feedback, and a serially loaded configuration chain
//  (shadow register + commit). Replaces the static-parameter combinational CLB in sim/PnR models.
//  Tiles daisy-chain CFG_DOUT -> CFG_DIN.
// PARAMETERS
//  K          3         LUT input count; LUT INIT width = 2**K
//  N_IN       4         CLB data inputs IN[N_IN-1:0]; SEL_W = $clog2(N_IN+1)
//  FG_SEL_IDX 1         IN index that drives the F/G select mux
//  RST_CFG    all-zero  CFG_W-bit config loaded into the active register on reset
//  CFG_W (localparam) = 2*2**K + 2*K*SEL_W + 3   (37 at defaults)
// PORTS
//  CLK       in   1      clock
//  RST       in   1      synchronous reset, active high
//  IN        in   N_IN   CLB data inputs
//  CE        in   1      FF clock enable (honoured only when FF_CE_EN=1)
//  F         out  1      F output
//  G         out  1      G output
//  Q         out  1      FF output, also LUT feedback source
//  CFG_EN    in   1      shift enable: CFG_DIN is shifted in this cycle
//  CFG_DIN   in   1      serial config in
//  CFG_COMMIT in  1      request transfer of shadow -> active
//  CFG_RB    in   1      readback request (see CONFIGURATION)
//  CFG_DOUT  out  1      serial config out = shadow[CFG_W-1]
//  CFG_BUSY  out  1      1 while state != OP
//  CFG_DONE  out  1      1-cycle pulse: commit accepted
//  CFG_ERR   out  1      1-cycle pulse: commit rejected
// BEHAVIOUR
//  Config layout, MSB..LSB: F_INIT | G_INIT | F_SEL[K*SEL_W] | G_SEL[K*SEL_W] | MUX_FG | FF_DSEL | FF_CE_EN.
//  LUT input i source = SEL field i: 0..N_IN-1 -> IN[v]; N_IN -> Q; >N_IN -> constant 0.
//  LUT out = INIT[{in[K-1],...,in[0]}]. MUX_FG=0: F=F_lut, G=G_lut.
//  MUX_FG=1: F=G=(IN[FG_SEL_IDX] ? G_lut : F_lut). F/G combinational from the active config, zero latency.
//  FF: D = FF_DSEL ? G : F; Q<=D on each CLK when (FF_CE_EN==0 || CE==1). 1-cycle latency.
//  Shift: shadow <= {shadow[CFG_W-2:0], CFG_DIN}; bit counter increments, saturating at CFG_W.
//   Excess bits pass through to CFG_DOUT (daisy chain).
//  FSM states: OP, SHIFT, COMMIT.
//   OP -> SHIFT when CFG_EN. SHIFT stays while CFG_EN.
//   OP/SHIFT -> COMMIT when CFG_COMMIT && !CFG_EN. SHIFT -> OP when both are low.
//   COMMIT (1 cycle), then -> OP:
//     count==CFG_W: active <= shadow, CFG_DONE=1.
//     else: active unchanged, CFG_ERR=1.
//     count <= 0 in both cases.
//  CFG_EN && CFG_COMMIT in the same cycle: shift wins, commit dropped (no pulse).
//  Shifting never disturbs F/G/Q; the new config takes effect the cycle after COMMIT.
//  RST (any state, incl. mid-shift):
//   - state=OP, active=RST_CFG, shadow=0, count=0, Q=0
//   - CFG_DOUT=0, CFG_BUSY=0, CFG_DONE=0, CFG_ERR=0
//   - F/G combinational from RST_CFG
//  RST has priority over every other input.
// CONFIGURATION
//  Macro XC20XX_CLB_READBACK_EN.
//  Defined: CFG_RB in OP with CFG_EN=0 copies active -> shadow and sets count=CFG_W;
//   the config is then shiftable out via CFG_DOUT (MSB first). Ignored outside OP.
//  Undefined: CFG_RB is present but ignored; shadow is written only by shifting.
// STRUCTURE
//  Package xc20xx_clb_pkg: FSM state enum (OP/SHIFT/COMMIT), field-order offset functions of (K,SEL_W),
//   sel_w(N_IN) function, SRC_ZERO encoding rule.
//  Sub-module xc20xx_lutk (K-input LUT, INIT as port), instantiated twice. Source muxes are inline.
// TESTING (K=3, N_IN=4, CFG_W=37)
//  1 Reset: RST=1 for 1 cycle -> Q=0, CFG_BUSY/DONE/ERR=0; F=G=0 with the zero RST_CFG.
//  2 Load: shift 37 bits with F_INIT=8'h96 (XOR), F_SEL={IN2,IN1,IN0}, then commit -> CFG_DONE pulses 1 cycle later;
//    IN=4'b0111 -> F=1; IN=4'b0011 -> F=0.
//  3 Short load: shift 36 bits, commit -> CFG_ERR pulses, F/G unchanged; next full 37-bit load is accepted.
//  4 Feedback toggle: G_INIT=8'h55 with all G_SELs=Q, FF_DSEL=1, FF_CE_EN=1.
//    Q toggles 0,1,0,1 while CE=1 and holds when CE=0.
//  5 Mid-shift RST after 20 bits -> FSM=OP, count=0, active=RST_CFG;
//    a following commit -> CFG_ERR. Simultaneous CFG_EN+CFG_COMMIT -> no DONE/ERR pulse.
//  6 Daisy chain of 2 tiles: 74 bits shifted, commit both -> each tile holds its own 37-bit word.
//    With READBACK_EN: CFG_RB, then 37 shifts -> CFG_DOUT reproduces the active word MSB first.

Source files
------------

// File: rtl/xc20xx_clb_pkg.sv
// Shared definitions for the XC20XX serially configured CLB: FSM states,
// configuration field offsets (LSB-relative) and source-select encoding.
package xc20xx_clb_pkg;

    typedef enum logic [1:0] {OP, SHIFT, COMMIT} cfg_state_e;

    function automatic int sel_w(input int n_in);
        return $clog2(n_in + 1);
    endfunction

    function automatic int off_ff_ce_en();
        return 0;
    endfunction

    function automatic int off_ff_dsel();
        return 1;
    endfunction

    function automatic int off_mux_fg();
        return 2;
    endfunction

    function automatic int off_g_sel();
        return 3;
    endfunction

    function automatic int off_f_sel(input int k, input int sw);
        return off_g_sel() + k * sw;
    endfunction

    function automatic int off_g_init(input int k, input int sw);
        return off_f_sel(k, sw) + k * sw;
    endfunction

    function automatic int off_f_init(input int k, input int sw);
        return off_g_init(k, sw) + 2 ** k;
    endfunction

    function automatic int cfg_w(input int k, input int sw);
        return off_f_init(k, sw) + 2 ** k;
    endfunction

    // Source select: 0..n_in-1 pick IN, n_in picks Q, anything above reads 0.
    function automatic int src_q(input int n_in);
        return n_in;
    endfunction

    function automatic int src_zero(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/xc20xx_lutk.sv
// K-input lookup table; truth table supplied as a port so it can follow
// the live configuration register.
module xc20xx_lutk #(
    parameter int K = 3
) (
    input  logic [2**K-1:0] init,
    input  logic [K-1:0]    addr,
    output logic            y
);
    assign y = init[addr];
endmodule

// File: rtl/xc20xx_clbk_seq.sv
// XC20XX CLB tile: F/G LUTs, F/G mux, D flip-flop and a shadow/commit config chain.
// Optional readback of the active word through the chain: `define XC20XX_CLB_READBACK_EN.
module xc20xx_clbk_seq
    import xc20xx_clb_pkg::*;
#(
    parameter int K          = 3,
    parameter int N_IN       = 4,
    parameter int FG_SEL_IDX = 1,
    parameter logic [cfg_w(K, sel_w(N_IN))-1:0] RST_CFG = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_IN-1:0] IN,
    input  logic            CE,
    output logic            F,
    output logic            G,
    output logic            Q,
    input  logic            CFG_EN,
    input  logic            CFG_DIN,
    input  logic            CFG_COMMIT,
    input  logic            CFG_RB,
    output logic            CFG_DOUT,
    output logic            CFG_BUSY,
    output logic            CFG_DONE,
    output logic            CFG_ERR
);
    localparam int SEL_W   = sel_w(N_IN);
    localparam int CFG_W   = cfg_w(K, SEL_W);
    localparam int CNT_W   = $clog2(CFG_W + 1);
    localparam int SRC_N   = 2 ** SEL_W;
    localparam int LUT_N   = 2 ** K;
    localparam int O_CEEN  = off_ff_ce_en();
    localparam int O_DSEL  = off_ff_dsel();
    localparam int O_MUX   = off_mux_fg();
    localparam int O_GSEL  = off_g_sel();
    localparam int O_FSEL  = off_f_sel(K, SEL_W);
    localparam int O_GINIT = off_g_init(K, SEL_W);
    localparam int O_FINIT = off_f_init(K, SEL_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    cfg_state_e       state, state_nxt;
    logic [CFG_W-1:0] active, shadow;
    logic [CNT_W-1:0] count;
    logic             full, do_shift, do_rb;
    logic [SRC_N-1:0] src;
    logic [K-1:0]     f_addr, g_addr;
    logic             f_lut, g_lut, fg_lut, d;

    // Padded to a full power of two so every select code indexes in range.
    always_comb begin
        src         = '0;
        src[N_IN-1:0] = IN;
        src[N_IN]   = Q;
    end

    for (genvar i = 0; i < K; i++) begin : g_src
        assign f_addr[i] = src[active[O_FSEL + i*SEL_W +: SEL_W]];
        assign g_addr[i] = src[active[O_GSEL + i*SEL_W +: SEL_W]];
    end

    xc20xx_lutk #(.K(K)) u_f_lut (
        .init (active[O_FINIT +: LUT_N]),
        .addr (f_addr),
        .y    (f_lut)
    );

    xc20xx_lutk #(.K(K)) u_g_lut (
        .init (active[O_GINIT +: LUT_N]),
        .addr (g_addr),
        .y    (g_lut)
    );

    assign fg_lut = IN[FG_SEL_IDX] ? g_lut : f_lut;
    assign F      = active[O_MUX] ? fg_lut : f_lut;
    assign G      = active[O_MUX] ? fg_lut : g_lut;
    assign d      = active[O_DSEL] ? G : F;

    always_ff @(posedge CLK) begin
        if (RST)
            Q <= 1'b0;
        else if (!active[O_CEEN] || CE)
            Q <= d;
    end

    // Shift beats commit when both are requested in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            OP, SHIFT: begin
                if (CFG_EN)
                    state_nxt = SHIFT;
                else if (CFG_COMMIT)
                    state_nxt = COMMIT;
                else
                    state_nxt = OP;
            end
            COMMIT:  state_nxt = OP;
            default: state_nxt = OP;
        endcase
    end

    assign full     = (count == CNT_FULL);
    assign do_shift = CFG_EN && (state != COMMIT);

`ifdef XC20XX_CLB_READBACK_EN
    assign do_rb = (state == OP) && CFG_RB && !CFG_EN;
`else
    logic unused_rb;
    assign unused_rb = CFG_RB;
    assign do_rb     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= OP;
            active <= RST_CFG;
            shadow <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (do_shift) begin
                shadow <= {shadow[CFG_W-2:0], CFG_DIN};
                if (!full)
                    count <= count + 1'b1;
            end else if (do_rb) begin
                shadow <= active;
                count  <= CNT_FULL;
            end
            if (state == COMMIT) begin
                if (full)
                    active <= shadow;
                count <= '0;
            end
        end
    end

    assign CFG_DOUT = shadow[CFG_W-1];
    assign CFG_BUSY = (state != OP);
    assign CFG_DONE = (state == COMMIT) && full;
    assign CFG_ERR  = (state == COMMIT) && !full;

endmodule
